fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 2000, WAIT-state cycles before the timeout abort (used only with FPU_ARB_TIMEOUT_EN).
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester n has an operation pending.
- req0_ready / req1_ready  out  1  one-cycle accept strobe for requester n.
- req0_a / req1_a  in  32  operand A, IEEE-754 single.
- req0_b / req1_b  in  32  operand B, IEEE-754 single.
- req0_op / req1_op  in  2  FPU opcode (00 add, 10 mul; passed through unchanged).
- rsp0_valid / rsp1_valid  out  1  one-cycle result strobe to requester n.
- rsp0_r / rsp1_r  out  32  result, valid when rspn_valid=1.
- rsp0_err / rsp1_err  out  1  result aborted by timeout, valid with rspn_valid.
- fpu_a, fpu_b  out  32  operands to the shared FPU.
- fpu_op  out  2  opcode to the FPU.
- fpu_start  out  1  FPU start pulse.
- fpu_r  in  32  FPU result.
- fpu_done  in  1  FPU completion pulse.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one operation SHALL be in flight at a time.
REQ-004 IDLE with no reqn_valid: stay in IDLE; all strobes 0.
REQ-005 IDLE with any reqn_valid: grant one requester, pulse its reqn_ready for exactly that cycle, register its a/b/op and the grant index, then go to ISSUE.
REQ-006 Both valid in the same IDLE cycle: grant the requester not served last (round-robin); after reset requester 0 wins.
REQ-007 A requester SHALL hold reqn_valid and its operands until reqn_ready; operands are sampled only in the ready cycle.
REQ-008 ISSUE: fpu_start=1 for exactly one cycle, fpu_a/fpu_b/fpu_op driven from the registered operands, then go to WAIT.
REQ-009 fpu_a/fpu_b/fpu_op SHALL stay stable from ISSUE until leaving WAIT, and SHALL hold their last value otherwise.
REQ-010 WAIT: on fpu_done=1, register fpu_r and go to RESP.
REQ-011 fpu_done outside WAIT SHALL be ignored.
REQ-012 RESP: for exactly one cycle, assert rspn_valid of the granted requester only, with rspn_r = captured result; update the round-robin pointer; go to IDLE.
REQ-013 rspn_r SHALL hold its value until the next response to that requester.
REQ-014 Latency: accept in cycle N, fpu_start in N+1; fpu_done in cycle D gives rspn_valid in D+1; next accept no earlier than D+2.
REQ-015 A new reqn_valid arriving during busy SHALL wait; no request is dropped or duplicated.

Reset
REQ-016 reset low SHALL immediately force: state IDLE; all ready, valid, err, start and busy outputs 0; fpu_a/fpu_b/fpu_op/rspn_r 0; round-robin pointer favouring requester 0; timeout counter 0.
REQ-017 Reset during ISSUE/WAIT/RESP SHALL abandon the operation with no response; a later fpu_done SHALL be ignored.

Configuration
REQ-018 Macro FPU_ARB_TIMEOUT_EN defined: a counter cleared on entering WAIT increments each WAIT cycle; on reaching TIMEOUT_CYCLES without fpu_done, go to RESP with rspn_err=1 and rspn_r=32'h7FC00000.
REQ-019 Macro FPU_ARB_TIMEOUT_EN undefined: no counter is built, rsp0_err/rsp1_err are tied 0, and WAIT lasts until fpu_done.

Verification
REQ-020 req0 add, A=32'h3FA00000, B=32'h3FC00000, op=00 -> one fpu_start, rsp0_valid with rsp0_r=32'h40300000 (2.75), rsp0_err=0.
REQ-021 req1 mul, A=32'h40200000, B=32'h40980000, op=10 -> rsp1_r=32'h413E0000 (11.875); rsp0_valid stays 0.
REQ-022 Both valid from reset, continuously -> grants alternate 0,1,0,1 and exactly one fpu_start per grant.
REQ-023 fpu_done held low, macro defined, TIMEOUT_CYCLES=16 -> rsp_valid 17 cycles after fpu_start with err=1 and r=32'h7FC00000.
REQ-024 reset pulsed low in WAIT, then fpu_done -> all outputs 0, no rsp_valid, next request served normally.
REQ-025 Spurious fpu_done in IDLE -> no state change, no rsp_valid.

Source files
------------

// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a single shared FPU, one operation in flight.
// Optional WAIT-state timeout abort is built only when FPU_ARB_TIMEOUT_EN is defined.
module fpu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req1_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req0_op,
  input  logic [1:0]  req1_op,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp0_r,
  output logic [31:0] rsp1_r,
  output logic        rsp0_err,
  output logic        rsp1_err,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  output logic        fpu_start,
  input  logic [31:0] fpu_r,
  input  logic        fpu_done,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        grant_q, grant_d;
  logic        prio_q, prio_d;
  logic [31:0] fpu_a_q, fpu_a_d;
  logic [31:0] fpu_b_q, fpu_b_d;
  logic [1:0]  fpu_op_q, fpu_op_d;
  logic [31:0] rsp0_r_q, rsp0_r_d;
  logic [31:0] rsp1_r_q, rsp1_r_d;
  logic        accept_s;
  logic        grant_s;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Grant selection and next-state logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    prio_d   = prio_q;
    fpu_a_d  = fpu_a_q;
    fpu_b_d  = fpu_b_q;
    fpu_op_d = fpu_op_q;
    rsp0_r_d = rsp0_r_q;
    rsp1_r_d = rsp1_r_q;
    accept_s = 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif

    // prio_q names the requester that wins a tie
    if (req0_valid && req1_valid) begin
      grant_s = prio_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          accept_s = 1'b1;
          grant_d  = grant_s;
          fpu_a_d  = grant_s ? req1_a  : req0_a;
          fpu_b_d  = grant_s ? req1_b  : req0_b;
          fpu_op_d = grant_s ? req1_op : req0_op;
          state_d  = S_ISSUE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
        cnt_d   = {CNT_W{1'b0}};
`endif
      end
      S_WAIT: begin
        if (fpu_done) begin
          state_d = S_RESP;
          if (grant_q) begin
            rsp1_r_d = fpu_r;
          end else begin
            rsp0_r_d = fpu_r;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          err_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 32'd1)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          if (grant_q) begin
            rsp1_r_d = QNAN;
          end else begin
            rsp0_r_d = QNAN;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`else
        end else begin
`endif
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        prio_d  = ~grant_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      prio_q   <= 1'b0;
      fpu_a_q  <= 32'd0;
      fpu_b_q  <= 32'd0;
      fpu_op_q <= 2'd0;
      rsp0_r_q <= 32'd0;
      rsp1_r_q <= 32'd0;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q    <= {CNT_W{1'b0}};
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      prio_q   <= prio_d;
      fpu_a_q  <= fpu_a_d;
      fpu_b_q  <= fpu_b_d;
      fpu_op_q <= fpu_op_d;
      rsp0_r_q <= rsp0_r_d;
      rsp1_r_q <= rsp1_r_d;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Ready is the only output that reacts to inputs within the accept cycle
  assign req0_ready = reset && accept_s && !grant_s;
  assign req1_ready = reset && accept_s &&  grant_s;

  assign fpu_start  = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE);
  assign rsp0_valid = (state_q == S_RESP) && !grant_q;
  assign rsp1_valid = (state_q == S_RESP) &&  grant_q;
  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_op     = fpu_op_q;
  assign rsp0_r     = rsp0_r_q;
  assign rsp1_r     = rsp1_r_q;

`ifdef FPU_ARB_TIMEOUT_EN
  assign rsp0_err   = rsp0_valid && err_q;
  assign rsp1_err   = rsp1_valid && err_q;
`else
  assign rsp0_err   = 1'b0;
  assign rsp1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed self-checking bench for fpu_arbiter; the timeout case runs only
// when FPU_ARB_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=16).
module tb_fpu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req1_a, req0_b, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_r, rsp1_r;
  logic [31:0] fpu_a, fpu_b, fpu_r;
  logic [1:0]  fpu_op;
  logic        fpu_start, fpu_done, busy;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int start_cnt = 0;

  fpu_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_r(rsp0_r), .rsp1_r(rsp1_r),
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_start(fpu_start),
    .fpu_r(fpu_r), .fpu_done(fpu_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fpu_start) start_cnt <= start_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction for a single requester, FPU answers two cycles after start
  task automatic run_op(input logic who, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] r);
    int s0;
    s0 = start_cnt;
    if (who) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    check_val("ready0", {31'd0, req0_ready}, {31'd0, ~who});
    check_val("ready1", {31'd0, req1_ready}, {31'd0, who});
    tick;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check_val("issue_start", {31'd0, fpu_start}, 32'd1);
    check_val("issue_a", fpu_a, a);
    check_val("issue_b", fpu_b, b);
    check_val("issue_op", {30'd0, fpu_op}, {30'd0, op});
    check_val("issue_busy", {31'd0, busy}, 32'd1);
    tick;
    #1;
    check_val("wait_start", {31'd0, fpu_start}, 32'd0);
    check_val("wait_a", fpu_a, a);
    tick;
    fpu_done = 1'b1; fpu_r = r;
    tick;
    fpu_done = 1'b0; fpu_r = 32'd0;
    #1;
    check_val("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, ~who});
    check_val("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, who});
    check_val("rsp_r", who ? rsp1_r : rsp0_r, r);
    check_val("rsp_err", {31'd0, rsp0_err | rsp1_err}, 32'd0);
    tick;
    #1;
    check_val("post_valid", {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
    check_val("post_r_hold", who ? rsp1_r : rsp0_r, r);
    check_val("post_busy", {31'd0, busy}, 32'd0);
    check_val("one_start", start_cnt - s0, 32'd1);
  endtask

  initial begin
    int s0;
    int cyc;
    logic g;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'd0; req1_a = 32'd0; req0_b = 32'd0; req1_b = 32'd0;
    req0_op = 2'd0; req1_op = 2'd0;
    fpu_r = 32'd0; fpu_done = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_start", {31'd0, fpu_start}, 32'd0);
    check_val("rst_rspv", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    check_val("rst_fpu_a", fpu_a, 32'd0);
    check_val("rst_rsp_r", rsp0_r | rsp1_r, 32'd0);
    tick; tick;
    reset = 1'b1;
    tick;

    run_op(1'b0, 32'h3FA0_0000, 32'h3FC0_0000, 2'b00, 32'h4030_0000);
    run_op(1'b1, 32'h4020_0000, 32'h4098_0000, 2'b10, 32'h413E_0000);
    check_val("rsp0_r_kept", rsp0_r, 32'h4030_0000);

    // spurious completion while idle
    fpu_done = 1'b1; fpu_r = 32'hDEAD_BEEF;
    tick;
    fpu_done = 1'b0;
    #1;
    check_val("spur_busy", {31'd0, busy}, 32'd0);
    check_val("spur_rspv", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    check_val("spur_r", rsp1_r, 32'h413E_0000);

    // round robin with both requesters continuously valid from reset
    reset = 1'b0;
    #1 reset = 1'b1;
    tick;
    req0_valid = 1'b1; req0_a = 32'h0000_00A0; req0_b = 32'd1; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 32'h0000_00A1; req1_b = 32'd2; req1_op = 2'b10;
    s0 = start_cnt;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      #1;
      check_val("rr_ready0", {31'd0, req0_ready}, {31'd0, ~g});
      check_val("rr_ready1", {31'd0, req1_ready}, {31'd0, g});
      tick;
      #1;
      check_val("rr_issue_a", fpu_a, g ? 32'h0000_00A1 : 32'h0000_00A0);
      check_val("rr_busy_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      tick;
      fpu_done = 1'b1; fpu_r = 32'h100 + k;
      tick;
      fpu_done = 1'b0;
      #1;
      check_val("rr_rspv", {30'd0, rsp1_valid, rsp0_valid}, g ? 32'd2 : 32'd1);
      tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick;
    check_val("rr_starts", start_cnt - s0, 32'd4);

    // reset in WAIT abandons the operation; late done is ignored
    req0_valid = 1'b1; req0_a = 32'h1111_1111; req0_b = 32'h2222_2222; req0_op = 2'b10;
    tick;
    req0_valid = 1'b0;
    tick;
    #1;
    reset = 1'b0;
    #1;
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_a", fpu_a, 32'd0);
    check_val("mid_rst_op", {30'd0, fpu_op}, 32'd0);
    check_val("mid_rst_r", rsp0_r | rsp1_r, 32'd0);
    reset = 1'b1;
    tick;
    fpu_done = 1'b1; fpu_r = 32'h5555_5555;
    tick;
    fpu_done = 1'b0;
    #1;
    check_val("late_done_rspv", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    check_val("late_done_busy", {31'd0, busy}, 32'd0);
    tick;
    run_op(1'b0, 32'h3F80_0000, 32'h3F80_0000, 2'b00, 32'h4000_0000);

`ifdef FPU_ARB_TIMEOUT_EN
    req1_valid = 1'b1; req1_a = 32'h4000_0000; req1_b = 32'h4000_0000; req1_op = 2'b10;
    tick;
    req1_valid = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      tick;
      cyc++;
      if (rsp1_valid) break;
    end
    check_val("to_latency", cyc, 32'd17);
    check_val("to_err", {31'd0, rsp1_err}, 32'd1);
    check_val("to_r", rsp1_r, 32'h7FC0_0000);
    check_val("to_rsp0", {31'd0, rsp0_valid}, 32'd0);
    tick;
`else
    cyc = 0;
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
